// File: rtl/present_decrypt_if.sv
// Start/done handshake bundle for the PRESENT-80 decryption core.
// start is sampled only while the core is idle. busy covers the key-expansion and round phases.
// done pulses for one cycle, and plaintext stays valid until the next run completes.
interface present_decrypt_if;
    logic        start;
    logic [79:0] key;
    logic [63:0] ciphertext;
    logic [63:0] plaintext;
    logic        busy;
    logic        done;
    logic [2:0]  dbg_state;

    modport master (
        output start, key, ciphertext,
        input  plaintext, busy, done, dbg_state
    );

    modport slave (
        input  start, key, ciphertext,
        output plaintext, busy, done, dbg_state
    );
endinterface

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryption: the key schedule runs forward to K32, the state is whitened,
// then 31 inverse rounds unwind the cipher while the key schedule is run backwards.
module present_decrypt (
    input  logic             clk,
    input  logic             rst_n,
    present_decrypt_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_KEYEXP = 3'd1;
    localparam logic [2:0] ST_WHITEN = 3'd2;
    localparam logic [2:0] ST_ROUND  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [79:0] kreg_q, kreg_d;
    logic [63:0] sreg_q, sreg_d;
    logic [4:0]  rc_q, rc_d;
    logic [63:0] pt_q, pt_d;
    logic        done_q, done_d;
    logic [79:0] key_prev;
    logic [63:0] perm_s;
    logic [63:0] sub_s;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        case (x)
            4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
            4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
            4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
            4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
        endcase
    endfunction

    // K_rc -> K_rc+1
    function automatic logic [79:0] fwd_update(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ rc;
        fwd_update = t;
    endfunction

    // K_rc+1 -> K_rc, undoing fwd_update step by step in reverse order
    function automatic logic [79:0] inv_update(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ rc;
        t[79:76]   = sbox_inv(t[79:76]);
        inv_update = {t[60:0], t[79:61]};
    endfunction

    for (genvar gi = 0; gi < 63; gi++) begin : g_inv_perm
        assign perm_s[gi] = sreg_q[(16 * gi) % 63];
    end
    assign perm_s[63] = sreg_q[63];

    for (genvar gj = 0; gj < 16; gj++) begin : g_inv_sbox
        assign sub_s[4*gj +: 4] = sbox_inv(perm_s[4*gj +: 4]);
    end

    assign key_prev = inv_update(kreg_q, rc_q);

    always_comb begin
        state_d = state_q;
        kreg_d  = kreg_q;
        sreg_d  = sreg_q;
        rc_d    = rc_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    kreg_d  = bus.key;
                    sreg_d  = bus.ciphertext;
                    rc_d    = 5'd1;
                    state_d = ST_KEYEXP;
                end
            end
            ST_KEYEXP: begin
                kreg_d = fwd_update(kreg_q, rc_q);
                if (rc_q == 5'd31) begin
                    state_d = ST_WHITEN;
                end else begin
                    rc_d = rc_q + 5'd1;
                end
            end
            ST_WHITEN: begin
                sreg_d  = sreg_q ^ kreg_q[79:16];
                rc_d    = 5'd31;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                sreg_d = sub_s ^ key_prev[79:16];
                kreg_d = key_prev;
                if (rc_q == 5'd1) begin
                    state_d = ST_DONE;
                end else begin
                    rc_d = rc_q - 5'd1;
                end
            end
            ST_DONE: begin
                pt_d    = sreg_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kreg_q  <= '0;
            sreg_q  <= '0;
            rc_q    <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kreg_q  <= kreg_d;
            sreg_q  <= sreg_d;
            rc_q    <= rc_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    assign bus.plaintext = pt_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q == ST_KEYEXP) || (state_q == ST_WHITEN) || (state_q == ST_ROUND);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_present_decrypt.sv
// Bench for present_decrypt: a cipher-level reference model drives a per-cycle compare,
// plus directed published test vectors and round-trip vectors.
module tb_present_decrypt;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    present_decrypt_if bus_if ();

    present_decrypt dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int sb[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    // Reference model state
    bit          m_run   = 1'b0;
    int          m_phase = 0;
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b0;
    logic [63:0] m_pt    = '0;
    logic [63:0] exp_q[$];
    logic [2:0]  idle_code;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %016h expected %016h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_sub(input logic [63:0] s, input bit inv);
        int isb[16];
        logic [63:0] r;
        logic [3:0] nib;
        r = '0;
        for (int v = 0; v < 16; v++) isb[sb[v]] = v;
        for (int j = 0; j < 16; j++) begin
            nib = 4'(s >> (4 * j));
            r = r | (64'(inv ? isb[nib] : sb[nib]) << (4 * j));
        end
        return r;
    endfunction

    // Forward pLayer moves bit b to position 16*b mod 63; the inverse gathers it back.
    function automatic logic [63:0] m_perm(input logic [63:0] s, input bit inv);
        logic [63:0] r;
        int p;
        r = '0;
        for (int b = 0; b < 63; b++) begin
            p = (16 * b) % 63;
            if (inv) r = r | (((s >> p) & 64'd1) << b);
            else     r = r | (((s >> b) & 64'd1) << p);
        end
        r = r | (s & (64'd1 << 63));
        return r;
    endfunction

    function automatic logic [79:0] m_key_next(input logic [79:0] k, input int rnd);
        logic [79:0] t;
        t = (k << 61) | (k >> 19);
        t = (t & ~(80'hF << 76)) | (80'(sb[t[79:76]]) << 76);
        t = t ^ (80'(rnd) << 15);
        return t;
    endfunction

    function automatic logic [63:0] m_encrypt(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int i = 1; i <= 31; i++) begin
            s = s ^ k[79:16];
            s = m_perm(m_sub(s, 1'b0), 1'b0);
            k = m_key_next(k, i);
        end
        return s ^ k[79:16];
    endfunction

    function automatic logic [63:0] m_decrypt(input logic [63:0] ct, input logic [79:0] key);
        logic [63:0] rk[1:32];
        logic [63:0] s;
        logic [79:0] k;
        k = key;
        rk[1] = k[79:16];
        for (int i = 1; i <= 31; i++) begin
            k = m_key_next(k, i);
            rk[i+1] = k[79:16];
        end
        s = ct ^ rk[32];
        for (int i = 31; i >= 1; i--) begin
            s = m_sub(m_perm(s, 1'b1), 1'b1) ^ rk[i];
        end
        return s;
    endfunction

    // Transaction-level timing model: accept in idle, done 64 edges later, idle again on edge 65.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 1'b0; m_phase = 0; m_busy = 1'b0; m_done = 1'b0; m_pt = '0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_run) begin
                m_phase++;
                if (m_phase == 64) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                    m_pt   = exp_q.pop_front();
                end
            end else if (bus_if.start) begin
                m_run   = 1'b1;
                m_phase = 0;
                exp_q.push_back(m_decrypt(bus_if.ciphertext, bus_if.key));
            end
            m_busy = m_run && (m_phase <= 62);
        end
    end

    initial forever begin
        @(negedge clk);
        check1("cycle busy", bus_if.busy, m_busy);
        check1("cycle done", bus_if.done, m_done);
        check64("cycle plaintext", bus_if.plaintext, m_pt);
    end

    task automatic run_vector(input string name, input logic [79:0] k, input logic [63:0] c,
                              input logic [63:0] p);
        int n;
        bit seen;
        @(posedge clk); #2;
        bus_if.start = 1'b1; bus_if.key = k; bus_if.ciphertext = c;
        @(posedge clk); #2;
        bus_if.start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (bus_if.done) seen = 1'b1;
        end
        check_int({name, " latency"}, n, 64);
        check64({name, " plaintext"}, bus_if.plaintext, p);
        @(posedge clk); #1;
        check1({name, " done width"}, bus_if.done, 1'b0);
        check1({name, " busy after"}, bus_if.busy, 1'b0);
        check64({name, " plaintext held"}, bus_if.plaintext, p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, d_cnt, first_e, second_e;
        logic [63:0] ct_a, ct_b;
        bus_if.start = 1'b0;
        bus_if.key = '0;
        bus_if.ciphertext = '0;

        // Published PRESENT-80 vectors pin the reference model itself.
        check64("model enc k0 p0", m_encrypt(64'h0, 80'h0), 64'h5579C1387B228445);
        check64("model enc kF p0", m_encrypt(64'h0, {80{1'b1}}), 64'hE72C46C0F5945049);
        check64("model enc k0 pF", m_encrypt({64{1'b1}}, 80'h0), 64'hA112FFC72F68417B);
        check64("model enc kF pF", m_encrypt({64{1'b1}}, {80{1'b1}}), 64'h3333DCD3213210D2);
        check64("model dec k0 p0", m_decrypt(64'h5579C1387B228445, 80'h0), 64'h0);
        check64("model dec kF pF", m_decrypt(64'h3333DCD3213210D2, {80{1'b1}}), {64{1'b1}});

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset plaintext", bus_if.plaintext, 64'h0);
        check1("reset busy", bus_if.busy, 1'b0);
        check1("reset done", bus_if.done, 1'b0);
        idle_code = bus_if.dbg_state;
        #1 rst_n = 1'b1;

        run_vector("k0 ct5579", 80'h0, 64'h5579C1387B228445, 64'h0);
        run_vector("kF ctE72C", {80{1'b1}}, 64'hE72C46C0F5945049, 64'h0);
        run_vector("k0 ctA112", 80'h0, 64'hA112FFC72F68417B, {64{1'b1}});
        run_vector("kF ct3333", {80{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}});

        ct_a = m_encrypt(64'hDEADBEEFCAFEF00D, 80'h0123456789ABCDEF0123);
        run_vector("roundtrip a", 80'h0123456789ABCDEF0123, ct_a, 64'hDEADBEEFCAFEF00D);
        ct_b = m_encrypt(64'h0000000000000001, 80'h80000000000000000001);
        run_vector("roundtrip b", 80'h80000000000000000001, ct_b, 64'h0000000000000001);

        // Back-to-back: start held high, inputs changed mid-run.
        @(posedge clk); #2;
        bus_if.start = 1'b1; bus_if.key = 80'h0; bus_if.ciphertext = 64'h5579C1387B228445;
        e = 0; d_cnt = 0; first_e = -1; second_e = -1;
        while (e < 140) begin
            @(posedge clk); #1;
            if (bus_if.done) begin
                d_cnt++;
                if (first_e < 0) begin
                    first_e = e;
                    check64("b2b first plaintext", bus_if.plaintext, 64'h0);
                end else begin
                    second_e = e;
                    check64("b2b second plaintext", bus_if.plaintext, {64{1'b1}});
                end
            end
            if (e == 20) begin
                bus_if.key = {80{1'b1}};
                bus_if.ciphertext = 64'h3333DCD3213210D2;
            end
            if (e == 66) bus_if.start = 1'b0;
            e++;
        end
        check_int("b2b first done edge", first_e, 64);
        check_int("b2b second done edge", second_e, 129);
        check_int("b2b done cycles", d_cnt, 2);

        // Reset at edge 40 of a run aborts it.
        @(posedge clk); #2;
        bus_if.start = 1'b1; bus_if.key = {80{1'b1}}; bus_if.ciphertext = 64'hE72C46C0F5945049;
        @(posedge clk); #2;
        bus_if.start = 1'b0;
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check64("abort plaintext", bus_if.plaintext, 64'h0);
        check1("abort busy", bus_if.busy, 1'b0);
        check1("abort done", bus_if.done, 1'b0);
        check_int("abort state idle", int'(bus_if.dbg_state), int'(idle_code));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run_vector("after reset", 80'h0, 64'hA112FFC72F68417B, {64{1'b1}});

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
